decode_ctrl_stage: RTL and testbench

//  Decode-stage control unit and D->E pipeline register of the pipelined CPU.

---
 rtl/decode_ctrl_stage.sv | 260 ++++++++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// rtl/decode_ctrl_stage.sv - Decode-stage control decoder and D->E control pipeline register
`timescale 1ns/1ps

module decode_ctrl_stage #(
   parameter int INSTR_W = 32
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [INSTR_W-1:0] InstrD,
   input  logic               InstrValidD,
   input  logic               StallE,
   input  logic               FlushE,
   output logic [1:0]         ImmSrcD,
   output logic [1:0]         RegSrcD,
   output logic [3:0]         CondE,
   output logic [1:0]         FlagWE,
   output logic               PCSE,
   output logic               RegWE,
   output logic               MemWE,
   output logic               MemtoRegE,
   output logic               ALUSrcE,
   output logic [1:0]         ALUControlE,
   output logic               BranchE,
   output logic [3:0]         RdE,
   output logic               ValidE,
   output logic               UndefE
);

   localparam logic [1:0] OP_DP     = 2'b00;
   localparam logic [1:0] OP_MEM    = 2'b01;
   localparam logic [1:0] OP_BRANCH = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   // Instruction fields (fixed 32-bit positions)
   logic [3:0] cond_f;
   logic [1:0] op_f;
   logic [5:0] funct_f;
   logic [3:0] cmd_f;
   logic       s_f;
   logic [3:0] rd_f;

   assign cond_f  = InstrD[31:28];
   assign op_f    = InstrD[27:26];
   assign funct_f = InstrD[25:20];
   assign cmd_f   = funct_f[4:1];
   assign s_f     = funct_f[0];
   assign rd_f    = InstrD[15:12];

   // Operand-register and immediate bits are consumed by the datapath, not here
   logic unused_instr_bits;
   assign unused_instr_bits = ^{InstrD[19:16], InstrD[11:0]};

   // Decoded control for the instruction currently in D
   logic [1:0] dec_flagw;
   logic       dec_pcs;
   logic       dec_regw;
   logic       dec_memw;
   logic       dec_memtoreg;
   logic       dec_alusrc;
   logic [1:0] dec_aluctl;
   logic       dec_branch;
   logic       dec_undef;
   logic [1:0] dec_immsrc;
   logic [1:0] dec_regsrc;
   logic       dec_arith;

   // E-stage pipeline register state and next-state
   logic [3:0] cond_q,     cond_d;
   logic [1:0] flagw_q,    flagw_d;
   logic       pcs_q,      pcs_d;
   logic       regw_q,     regw_d;
   logic       memw_q,     memw_d;
   logic       memtoreg_q, memtoreg_d;
   logic       alusrc_q,   alusrc_d;
   logic [1:0] aluctl_q,   aluctl_d;
   logic       branch_q,   branch_d;
   logic [3:0] rd_q,       rd_d;
   logic       valid_q,    valid_d;
   logic       undef_q,    undef_d;

   // Main decode plus ALU decode; undefined encodings drop every side effect
   always_comb begin
      dec_flagw    = 2'b00;
      dec_pcs      = 1'b0;
      dec_regw     = 1'b0;
      dec_memw     = 1'b0;
      dec_memtoreg = 1'b0;
      dec_alusrc   = 1'b0;
      dec_aluctl   = ALU_ADD;
      dec_branch   = 1'b0;
      dec_undef    = 1'b0;
      dec_immsrc   = 2'b00;
      dec_regsrc   = 2'b00;
      dec_arith    = 1'b0;

      case (op_f)
         OP_DP: begin
            dec_regw   = 1'b1;
            dec_alusrc = funct_f[5];
            case (cmd_f)
               CMD_ADD: begin
                  dec_aluctl = ALU_ADD;
                  dec_arith  = 1'b1;
               end
               CMD_SUB: begin
                  dec_aluctl = ALU_SUB;
                  dec_arith  = 1'b1;
               end
               CMD_AND: dec_aluctl = ALU_AND;
               CMD_ORR: dec_aluctl = ALU_ORR;
               CMD_CMP: begin
                  // Compare only exists for its flag effect, so S=0 has no meaning
                  dec_aluctl = ALU_SUB;
                  dec_arith  = 1'b1;
                  dec_regw   = 1'b0;
                  dec_undef  = ~s_f;
               end
               default: dec_undef = 1'b1;
            endcase
            dec_flagw = {s_f, s_f & dec_arith};
         end
         OP_MEM: begin
            dec_alusrc = 1'b1;
            dec_immsrc = 2'b01;
            dec_aluctl = ALU_ADD;
            if (funct_f[0]) begin
               dec_regw     = 1'b1;
               dec_memtoreg = 1'b1;
               dec_regsrc   = 2'b00;
            end else begin
               dec_memw   = 1'b1;
               dec_regsrc = 2'b10;
            end
         end
         OP_BRANCH: begin
            dec_branch = 1'b1;
            dec_alusrc = 1'b1;
            dec_immsrc = 2'b10;
            dec_regsrc = 2'b01;
            dec_aluctl = ALU_ADD;
         end
         default: dec_undef = 1'b1;
      endcase

      // Undefined slots keep cond/Rd for debug visibility but request nothing
      if (dec_undef) begin
         dec_regw     = 1'b0;
         dec_memw     = 1'b0;
         dec_branch   = 1'b0;
         dec_flagw    = 2'b00;
         dec_memtoreg = 1'b0;
         dec_alusrc   = 1'b0;
         dec_aluctl   = ALU_ADD;
      end

      // PC write must see the post-suppression RegW so CMP/undef never redirect
      dec_pcs = dec_branch | (dec_regw & (rd_f == 4'hF));
   end

   assign ImmSrcD = dec_immsrc;
   assign RegSrcD = dec_regsrc;

   // Next E contents: decoded bundle for a real instruction, else a bubble
   always_comb begin
      cond_d     = 4'h0;
      flagw_d    = 2'b00;
      pcs_d      = 1'b0;
      regw_d     = 1'b0;
      memw_d     = 1'b0;
      memtoreg_d = 1'b0;
      alusrc_d   = 1'b0;
      aluctl_d   = 2'b00;
      branch_d   = 1'b0;
      rd_d       = 4'h0;
      valid_d    = 1'b0;
      undef_d    = 1'b0;
      if (InstrValidD) begin
         cond_d     = cond_f;
         flagw_d    = dec_flagw;
         pcs_d      = dec_pcs;
         regw_d     = dec_regw;
         memw_d     = dec_memw;
         memtoreg_d = dec_memtoreg;
         alusrc_d   = dec_alusrc;
         aluctl_d   = dec_aluctl;
         branch_d   = dec_branch;
         rd_d       = rd_f;
         valid_d    = 1'b1;
         undef_d    = dec_undef;
      end
   end

   // E register: reset/flush load a bubble, flush beats stall, stall holds
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         cond_q     <= 4'h0;
         flagw_q    <= 2'b00;
         pcs_q      <= 1'b0;
         regw_q     <= 1'b0;
         memw_q     <= 1'b0;
         memtoreg_q <= 1'b0;
         alusrc_q   <= 1'b0;
         aluctl_q   <= 2'b00;
         branch_q   <= 1'b0;
         rd_q       <= 4'h0;
         valid_q    <= 1'b0;
         undef_q    <= 1'b0;
      end else if (FlushE) begin
         cond_q     <= 4'h0;
         flagw_q    <= 2'b00;
         pcs_q      <= 1'b0;
         regw_q     <= 1'b0;
         memw_q     <= 1'b0;
         memtoreg_q <= 1'b0;
         alusrc_q   <= 1'b0;
         aluctl_q   <= 2'b00;
         branch_q   <= 1'b0;
         rd_q       <= 4'h0;
         valid_q    <= 1'b0;
         undef_q    <= 1'b0;
      end else if (!StallE) begin
         cond_q     <= cond_d;
         flagw_q    <= flagw_d;
         pcs_q      <= pcs_d;
         regw_q     <= regw_d;
         memw_q     <= memw_d;
         memtoreg_q <= memtoreg_d;
         alusrc_q   <= alusrc_d;
         aluctl_q   <= aluctl_d;
         branch_q   <= branch_d;
         rd_q       <= rd_d;
         valid_q    <= valid_d;
         undef_q    <= undef_d;
      end
   end

   assign CondE       = cond_q;
   assign FlagWE      = flagw_q;
   assign PCSE        = pcs_q;
   assign RegWE       = regw_q;
   assign MemWE       = memw_q;
   assign MemtoRegE   = memtoreg_q;
   assign ALUSrcE     = alusrc_q;
   assign ALUControlE = aluctl_q;
   assign BranchE     = branch_q;
   assign RdE         = rd_q;
   assign ValidE      = valid_q;
   assign UndefE      = undef_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb/tb_decode_ctrl_stage.sv - Scoreboard testbench for decode_ctrl_stage
`timescale 1ns/1ps

module tb_decode_ctrl_stage;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [31:0] InstrD;
   logic        InstrValidD;
   logic        StallE;
   logic        FlushE;
   logic [1:0]  ImmSrcD;
   logic [1:0]  RegSrcD;
   logic [3:0]  CondE;
   logic [1:0]  FlagWE;
   logic        PCSE;
   logic        RegWE;
   logic        MemWE;
   logic        MemtoRegE;
   logic        ALUSrcE;
   logic [1:0]  ALUControlE;
   logic        BranchE;
   logic [3:0]  RdE;
   logic        ValidE;
   logic        UndefE;

   int tests = 0;
   int fails = 0;

   logic [19:0] exp_q[$];
   string       name_q[$];

   always #5 CLK = ~CLK;

   decode_ctrl_stage #(.INSTR_W(32)) dut (
      .CLK(CLK), .Reset(Reset), .InstrD(InstrD), .InstrValidD(InstrValidD),
      .StallE(StallE), .FlushE(FlushE), .ImmSrcD(ImmSrcD), .RegSrcD(RegSrcD),
      .CondE(CondE), .FlagWE(FlagWE), .PCSE(PCSE), .RegWE(RegWE), .MemWE(MemWE),
      .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
      .BranchE(BranchE), .RdE(RdE), .ValidE(ValidE), .UndefE(UndefE)
   );

   logic [19:0] got_e;
   assign got_e = {ValidE, UndefE, CondE, FlagWE, PCSE, RegWE, MemWE,
                   MemtoRegE, ALUSrcE, ALUControlE, BranchE, RdE};

   // Bundle layout: valid undef cond[4] flagw[2] pcs regw memw memtoreg alusrc aluctl[2] branch rd[4]
   function automatic logic [19:0] ex(input logic v, input logic u, input logic [3:0] c,
                                      input logic [1:0] fw, input logic pcs, input logic rw,
                                      input logic mw, input logic m2r, input logic as,
                                      input logic [1:0] ac, input logic br, input logic [3:0] rd);
      return {v, u, c, fw, pcs, rw, mw, m2r, as, ac, br, rd};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // One clock of stimulus: drive D inputs, check D-stage selects, queue the E result
   task automatic step(input string nm, input logic [31:0] instr, input logic vld,
                       input logic stall, input logic flush, input logic [19:0] exp,
                       input logic [1:0] imm, input logic [1:0] rsrc);
      #1;
      InstrD      = instr;
      InstrValidD = vld;
      StallE      = stall;
      FlushE      = flush;
      #1;
      chk({nm, "_ImmSrcD"}, 32'(ImmSrcD), 32'(imm));
      chk({nm, "_RegSrcD"}, 32'(RegSrcD), 32'(rsrc));
      @(posedge CLK);
      exp_q.push_back(exp);
      name_q.push_back(nm);
   endtask

   // Monitor: compare the E bundle once per cycle against the oldest expectation
   always @(negedge CLK) begin
      if (exp_q.size() != 0) begin
         logic [19:0] e;
         string       n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         chk({n, "_E"}, 32'(got_e), 32'(e));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   localparam logic [31:0] I_ADD    = 32'hE0821003;
   localparam logic [31:0] I_SUBS   = 32'hE2521001;
   localparam logic [31:0] I_CMP    = 32'hE1520002;
   localparam logic [31:0] I_LDR    = 32'hE5910004;
   localparam logic [31:0] I_STR    = 32'hE5810004;
   localparam logic [31:0] I_B      = 32'hEA000002;
   localparam logic [31:0] I_ADDPC  = 32'hE28FF000;
   localparam logic [31:0] I_OP11   = 32'hEC000000;
   localparam logic [31:0] I_CMPNS  = 32'hE1420002;
   localparam logic [31:0] I_EOR    = 32'hE0221003;
   localparam logic [31:0] I_ANDS   = 32'hE0121003;
   localparam logic [31:0] I_ORR    = 32'hE1821003;
   localparam logic [31:0] I_ADDEQ  = 32'h00821003;
   localparam logic [31:0] I_CMPRDF = 32'hE152F002;
   localparam logic [31:0] I_LDRPC  = 32'hE591F004;

   logic [19:0] e_add, e_bub;

   initial begin
      e_add = ex(1, 0, 4'hE, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0, 4'h1);
      e_bub = 20'h0;

      Reset       = 1'b1;
      InstrD      = I_ADD;
      InstrValidD = 1'b1;
      StallE      = 1'b0;
      FlushE      = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_state", 32'(got_e), 32'(e_bub));
      Reset = 1'b0;
      @(posedge CLK);

      // Main decode vectors
      step("add",    I_ADD,    1, 0, 0, e_add, 2'b00, 2'b00);
      step("subs",   I_SUBS,   1, 0, 0, ex(1,0,4'hE,2'b11,0,1,0,0,1,2'b01,0,4'h1), 2'b00, 2'b00);
      step("cmp",    I_CMP,    1, 0, 0, ex(1,0,4'hE,2'b11,0,0,0,0,0,2'b01,0,4'h0), 2'b00, 2'b00);
      step("ldr",    I_LDR,    1, 0, 0, ex(1,0,4'hE,2'b00,0,1,0,1,1,2'b00,0,4'h0), 2'b01, 2'b00);
      step("str",    I_STR,    1, 0, 0, ex(1,0,4'hE,2'b00,0,0,1,0,1,2'b00,0,4'h0), 2'b01, 2'b10);
      step("b",      I_B,      1, 0, 0, ex(1,0,4'hE,2'b00,1,0,0,0,1,2'b00,1,4'h0), 2'b10, 2'b01);
      step("addpc",  I_ADDPC,  1, 0, 0, ex(1,0,4'hE,2'b00,1,1,0,0,1,2'b00,0,4'hF), 2'b00, 2'b00);
      step("op11",   I_OP11,   1, 0, 0, ex(1,1,4'hE,2'b00,0,0,0,0,0,2'b00,0,4'h0), 2'b00, 2'b00);
      step("cmpns",  I_CMPNS,  1, 0, 0, ex(1,1,4'hE,2'b00,0,0,0,0,0,2'b00,0,4'h0), 2'b00, 2'b00);
      step("eor",    I_EOR,    1, 0, 0, ex(1,1,4'hE,2'b00,0,0,0,0,0,2'b00,0,4'h1), 2'b00, 2'b00);
      step("ands",   I_ANDS,   1, 0, 0, ex(1,0,4'hE,2'b10,0,1,0,0,0,2'b10,0,4'h1), 2'b00, 2'b00);
      step("orr",    I_ORR,    1, 0, 0, ex(1,0,4'hE,2'b00,0,1,0,0,0,2'b11,0,4'h1), 2'b00, 2'b00);
      step("addeq",  I_ADDEQ,  1, 0, 0, ex(1,0,4'h0,2'b00,0,1,0,0,0,2'b00,0,4'h1), 2'b00, 2'b00);
      step("cmprdf", I_CMPRDF, 1, 0, 0, ex(1,0,4'hE,2'b11,0,0,0,0,0,2'b01,0,4'hF), 2'b00, 2'b00);
      step("ldrpc",  I_LDRPC,  1, 0, 0, ex(1,0,4'hE,2'b00,1,1,0,1,1,2'b00,0,4'hF), 2'b01, 2'b00);
      step("invalid", I_ADD,   0, 0, 0, e_bub, 2'b00, 2'b00);

      // Stall holds, flush overrides stall
      step("ld_add", I_ADD,    1, 0, 0, e_add, 2'b00, 2'b00);
      for (int i = 0; i < 3; i++)
         step($sformatf("stall%0d", i), I_STR, 1, 1, 0, e_add, 2'b01, 2'b10);
      step("stall_flush", I_STR, 1, 1, 1, e_bub, 2'b01, 2'b10);
      step("after_flush", I_ADD, 1, 0, 0, e_add, 2'b00, 2'b00);
      step("flush_only",  I_SUBS, 1, 0, 1, e_bub, 2'b00, 2'b00);

      // Asynchronous reset between edges
      @(negedge CLK);
      #1;
      InstrD      = I_ADD;
      InstrValidD = 1'b1;
      StallE      = 1'b0;
      FlushE      = 1'b0;
      step("pre_rst", I_ADD, 1, 0, 0, e_add, 2'b00, 2'b00);
      @(negedge CLK);
      #1;
      Reset = 1'b1;
      #1;
      chk("rst_async", 32'(got_e), 32'(e_bub));
      @(posedge CLK);
      #1;
      chk("rst_hold", 32'(got_e), 32'(e_bub));
      Reset = 1'b0;
      step("rst_release", I_ADD, 1, 0, 0, e_add, 2'b00, 2'b00);

      @(negedge CLK);
      #1;
      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
